mac_sequencer: RTL and testbench

Operand sequencer and accumulator wrapped around the shift-add multiplier (`EA`/`EB` load, M-cycle shift-add, product on `P`). It accepts operand pairs over a valid/ready stream and pulses `EA`/`EB` with the operands. It waits out the multiplier's fixed latency, captures `P` and adds it into a running sum. When a term flagged `in_last` completes, it presents the sum on a valid/ready output. This makes the multiplier a dot-product/MAC engine.

---
 rtl/mac_sequencer.sv | 96 +++++++++
 tb/tb_mac_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Operand sequencer and accumulator around a shift-add multiplier.
// Streams operand pairs into the multiplier, accumulates products, emits the dot product.
module mac_sequencer #(
  parameter int M     = 8,
  parameter int N     = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_a,
  input  logic [M-1:0]     in_b,
  input  logic             in_last,
  output logic             EA,
  output logic             EB,
  output logic [M-1:0]     dataA,
  output logic [M-1:0]     dataB,
  input  logic [N-1:0]     P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CW = $clog2(M + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, ACC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [M-1:0]     op_a;
  logic [M-1:0]     op_b;
  logic             op_last;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum_ext;

  // The extra top bit of the widened sum is the wrap-around carry.
  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - N){1'b0}}, P};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_last <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a    <= in_a;
            op_b    <= in_b;
            op_last <= in_last;
            state   <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(M)) state <= ACC;
        end
        ACC: begin
          acc   <= sum_ext[ACC_W-1:0];
          ovf   <= ovf | sum_ext[ACC_W];
          state <= op_last ? DONE : IDLE;
        end
        DONE: begin
          if (out_ready) begin
            acc   <= '0;
            ovf   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers double as the multiplier data bus, so they hold between loads.
  assign in_ready  = (state == IDLE);
  assign EA        = (state == LOAD);
  assign EB        = (state == LOAD);
  assign dataA     = op_a;
  assign dataB     = op_b;
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural shift-add multiplier model.
module tb_mac_sequencer;
  localparam int M = 8;
  localparam int N = 16;
  localparam int ACC_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [M-1:0]     in_a;
  logic [M-1:0]     in_b;
  logic             in_last;
  logic             EA;
  logic             EB;
  logic [M-1:0]     dataA;
  logic [M-1:0]     dataB;
  logic [N-1:0]     P;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  int vectors = 0;
  int miscompares = 0;

  mac_sequencer #(.M(M), .N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .EA(EA), .EB(EB),
    .dataA(dataA), .dataB(dataB), .P(P), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Multiplier model: P shows junk until the (M+1)th edge after the load edge.
  logic [M-1:0] ma, mb;
  int           mcnt = M + 1;
  initial P = 16'hFFFF;
  always @(posedge clk) begin
    if (EA) begin
      ma   <= dataA;
      mb   <= dataB;
      mcnt <= 0;
      P    <= 16'h5A5A;
    end else if (mcnt < M + 1) begin
      mcnt <= mcnt + 1;
      if (mcnt == M) P <= N'(ma) * N'(mb);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one pair and observes until the result (last) or the next IDLE (not last).
  task automatic run_term(input logic [M-1:0] a, input logic [M-1:0] b, input logic last,
                          output int lat, output int ea_cnt, output int rdy_low,
                          output int ea_eb_diff, output logic [M-1:0] da, output logic [M-1:0] db);
    int guard;
    lat = -1; ea_cnt = 0; rdy_low = 0; ea_eb_diff = 0; da = '0; db = '0;
    guard = 0;
    while (!in_ready && guard < 100) begin cycle(); guard++; end
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (EA !== EB) ea_eb_diff++;
      if (EA === 1'b1) begin ea_cnt++; da = dataA; db = dataB; end
      if (last && out_valid === 1'b1) begin lat = c; break; end
      if (!last && in_ready === 1'b1) begin lat = c; break; end
      if (in_ready !== 1'b1) rdy_low++;
      cycle();
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    vectors++;
    if ({in_ready, EA, EB, out_valid, out_ovf} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 10000", {in_ready, EA, EB, out_valid, out_ovf});
    end
    vectors++;
    if (out_sum !== '0 || dataA !== '0 || dataB !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got sum=%0d dA=%0d dB=%0d expected 0/0/0", out_sum, dataA, dataB);
    end
  endtask

  task automatic test_single();
    int lat, ea_cnt, rdy_low, diff;
    logic [M-1:0] da, db;
    run_term(8'd3, 8'd5, 1'b1, lat, ea_cnt, rdy_low, diff, da, db);
    vectors++;
    if (ea_cnt != 1 || diff != 0) begin
      miscompares++;
      $display("FAIL single_strobe: got ea_cycles=%0d ea_eb_diff=%0d expected 1/0", ea_cnt, diff);
    end
    vectors++;
    if (da !== 8'd3 || db !== 8'd5) begin
      miscompares++;
      $display("FAIL single_data: got %0d,%0d expected 3,5", da, db);
    end
    vectors++;
    if (lat != 12) begin
      miscompares++;
      $display("FAIL single_latency: got %0d expected 12", lat);
    end
    vectors++;
    if (out_sum !== 24'd15 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL single_sum: got %0d ovf=%b expected 15 ovf=0", out_sum, out_ovf);
    end
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_dot_product();
    int lat, ea_cnt, rdy_low, diff;
    logic [M-1:0] da, db;
    logic [M-1:0] av [3] = '{8'd1, 8'd3, 8'd255};
    logic [M-1:0] bv [3] = '{8'd2, 8'd4, 8'd255};
    for (int i = 0; i < 3; i++) begin
      run_term(av[i], bv[i], (i == 2), lat, ea_cnt, rdy_low, diff, da, db);
      vectors++;
      if (lat != 12 || rdy_low != 11) begin
        miscompares++;
        $display("FAIL dot_term%0d_timing: got lat=%0d ready_low=%0d expected 12/11", i, lat, rdy_low);
      end
    end
    vectors++;
    if (out_sum !== 24'd65039 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL dot_sum: got %0d ovf=%b expected 65039 ovf=0", out_sum, out_ovf);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat, ea_cnt, rdy_low, diff, bad;
    logic [M-1:0] da, db;
    run_term(8'd4, 8'd6, 1'b1, lat, ea_cnt, rdy_low, diff, da, db);
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (out_valid !== 1'b1 || out_sum !== 24'd24 || in_ready !== 1'b0 || EA !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL backpressure_hold: got %0d bad cycles expected 0", bad);
    end
    in_valid = 1'b0;
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
      miscompares++;
      $display("FAIL backpressure_release: got valid=%b ready=%b acc=%0d expected 0/1/0",
               out_valid, in_ready, out_sum);
    end
    cycle();
    vectors++;
    if (EA !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_no_accept: got EA=%b ready=%b expected 0/1", EA, in_ready);
    end
  endtask

  task automatic test_overflow();
    int lat, ea_cnt, rdy_low, diff;
    logic [M-1:0] da, db;
    for (int i = 1; i <= 259; i++)
      run_term(8'd255, 8'd255, (i == 259), lat, ea_cnt, rdy_low, diff, da, db);
    vectors++;
    if (out_sum !== 24'd64259 || out_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sum: got %0d ovf=%b expected 64259 ovf=1", out_sum, out_ovf);
    end
    handshake();
    run_term(8'd2, 8'd2, 1'b1, lat, ea_cnt, rdy_low, diff, da, db);
    vectors++;
    if (out_sum !== 24'd4 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: got %0d ovf=%b expected 4 ovf=0", out_sum, out_ovf);
    end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int lat, ea_cnt, rdy_low, diff;
    logic [M-1:0] da, db;
    run_term(8'd10, 8'd10, 1'b0, lat, ea_cnt, rdy_low, diff, da, db);
    in_valid = 1'b1; in_a = 8'd50; in_b = 8'd60; in_last = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got ready=%b valid=%b acc=%0d expected 1/0/0",
               in_ready, out_valid, out_sum);
    end
    run_term(8'd7, 8'd9, 1'b1, lat, ea_cnt, rdy_low, diff, da, db);
    vectors++;
    if (out_sum !== 24'd63 || out_ovf !== 1'b0 || lat != 12) begin
      miscompares++;
      $display("FAIL midrun_next: got %0d ovf=%b lat=%0d expected 63 ovf=0 lat=12", out_sum, out_ovf, lat);
    end
    handshake();
  endtask

  task automatic test_zero_operand();
    int lat, ea_cnt, rdy_low, diff;
    logic [M-1:0] da, db;
    run_term(8'd0, 8'd200, 1'b1, lat, ea_cnt, rdy_low, diff, da, db);
    vectors++;
    if (out_sum !== '0 || lat != 12) begin
      miscompares++;
      $display("FAIL zero_operand: got %0d lat=%0d expected 0 lat=12", out_sum, lat);
    end
    vectors++;
    if (da !== 8'd0 || db !== 8'd200) begin
      miscompares++;
      $display("FAIL zero_data: got %0d,%0d expected 0,200", da, db);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_single();
    test_dot_product();
    test_backpressure();
    test_overflow();
    test_reset_mid_run();
    test_zero_operand();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
